// File: rtl/hazard_pkg.sv
// Shared types for the pipeline stall controller: state encoding, control-output
// bundles (including the value forced while in reset) and legal parameter ranges.
package hazard_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    BUSY  = 2'd2
  } state_e;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_stall;
  } ctl_t;

  localparam ctl_t CTL_RESET     = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam ctl_t CTL_RUN       = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  localparam ctl_t CTL_FLUSH_REQ = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  localparam ctl_t CTL_FLUSH     = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctl_t CTL_STALL     = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctl_t CTL_BUSY      = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

  localparam int FLUSH_CYCLES_MIN   = 1;
  localparam int FLUSH_CYCLES_MAX   = 4;
  localparam int MAX_LOAD_STALL_MIN = 1;
  localparam int MAX_LOAD_STALL_MAX = 7;
  localparam int BUSY_TIMEOUT_MIN   = 2;
  localparam int BUSY_TIMEOUT_MAX   = 255;

  function automatic int clamp_param(input int v, input int lo, input int hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int cnt_width(input int max_val);
    return $clog2(max_val) + 1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that clears on request and holds once it reaches MAX.
module sat_counter #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             sat_o
);

  logic [WIDTH-1:0] count_q;

  assign sat_o   = (count_q == MAX);
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear_i) begin
      count_q <= '0;
    end else if (inc_i && !sat_o) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_stall_controller.sv
// Sequences PC / IF-ID / ID-EX / EX enables from hazard requests and long-op handshake.
// Define HAZARD_STATS_EN to populate the load-stall, flush and busy-cycle statistics.
module pipeline_stall_controller
  import hazard_pkg::*;
#(
  parameter int FLUSH_CYCLES   = 1,
  parameter int MAX_LOAD_STALL = 1,
  parameter int BUSY_TIMEOUT   = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stallReq,
  input  logic        flushReq,
  input  logic        longOpStart,
  input  logic        longOpDone,
  output logic        pcWrite,
  output logic        ifIdWrite,
  output logic        ifIdFlush,
  output logic        idExFlush,
  output logic        exStall,
  output logic        stallErr,
  output logic        busyErr,
  output logic [31:0] loadStallCount,
  output logic [31:0] flushCount,
  output logic [31:0] busyCycleCount
);

  localparam int FC  = clamp_param(FLUSH_CYCLES, FLUSH_CYCLES_MIN, FLUSH_CYCLES_MAX);
  localparam int MLS = clamp_param(MAX_LOAD_STALL, MAX_LOAD_STALL_MIN, MAX_LOAD_STALL_MAX);
  localparam int BT  = clamp_param(BUSY_TIMEOUT, BUSY_TIMEOUT_MIN, BUSY_TIMEOUT_MAX);
  // The flush counter counts FLUSH-state cycles already spent; the last one is FC-2.
  localparam int FLUSH_LAST = (FC > 1) ? FC - 2 : 0;
  localparam int FW = cnt_width(FC);
  localparam int SW = cnt_width(MLS);
  localparam int BW = cnt_width(BT);

  state_e state_q, state_d;
  logic   pend_q, pend_d;
  logic   stall_err_q, stall_err_d;
  logic   busy_err_q, busy_err_d;
  ctl_t   ctl, ctl_out;

  logic          stall_inc, stall_sat;
  logic          flush_clr, flush_inc, flush_last;
  logic          busy_clr, busy_inc, busy_sat;
  logic          do_flush;
  logic [SW-1:0] stall_cnt;
  logic [FW-1:0] flush_cnt;
  logic [BW-1:0] busy_cnt;
  logic          unused_cnt;

  sat_counter #(.WIDTH(SW), .MAX(SW'(MLS))) u_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clear_i(!stallReq), .inc_i(stall_inc),
    .count_o(stall_cnt), .sat_o(stall_sat)
  );

  sat_counter #(.WIDTH(FW), .MAX(FW'(FLUSH_LAST))) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clear_i(flush_clr), .inc_i(flush_inc),
    .count_o(flush_cnt), .sat_o(flush_last)
  );

  sat_counter #(.WIDTH(BW), .MAX(BW'(BT))) u_busy_cnt (
    .clk(clk), .rst_n(rst_n), .clear_i(busy_clr), .inc_i(busy_inc),
    .count_o(busy_cnt), .sat_o(busy_sat)
  );

  assign unused_cnt = ^{stall_cnt, flush_cnt, busy_cnt};

  always_comb begin
    ctl         = CTL_RUN;
    state_d     = state_q;
    pend_d      = pend_q;
    stall_err_d = stall_err_q;
    busy_err_d  = busy_err_q;
    stall_inc   = 1'b0;
    flush_clr   = 1'b0;
    flush_inc   = 1'b0;
    busy_clr    = 1'b0;
    busy_inc    = 1'b0;
    do_flush    = 1'b0;

    unique case (state_q)
      RUN: begin
        if (flushReq) begin
          do_flush = 1'b1;
        end else if (longOpStart) begin
          // A done in the start cycle is a zero-wait op: never enter BUSY.
          if (!longOpDone) begin
            state_d  = BUSY;
            busy_clr = 1'b1;
          end
        end else if (stallReq) begin
          if (stall_sat) begin
            stall_err_d = 1'b1;
          end else begin
            ctl       = CTL_STALL;
            stall_inc = 1'b1;
          end
        end
      end
      FLUSH: begin
        ctl = CTL_FLUSH;
        if (flushReq) begin
          flush_clr = 1'b1;
        end else if (flush_last) begin
          state_d = RUN;
        end else begin
          flush_inc = 1'b1;
        end
      end
      BUSY: begin
        if (longOpDone || busy_sat) begin
          state_d  = RUN;
          pend_d   = 1'b0;
          do_flush = pend_q || flushReq;
          if (!longOpDone) busy_err_d = 1'b1;
        end else begin
          ctl      = CTL_BUSY;
          busy_inc = 1'b1;
          if (flushReq) pend_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase

    if (do_flush) begin
      ctl       = CTL_FLUSH_REQ;
      flush_clr = 1'b1;
      state_d   = (FC > 1) ? FLUSH : RUN;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      pend_q      <= 1'b0;
      stall_err_q <= 1'b0;
      busy_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      stall_err_q <= stall_err_d;
      busy_err_q  <= busy_err_d;
    end
  end

  assign ctl_out   = rst_n ? ctl : CTL_RESET;
  assign pcWrite   = ctl_out.pc_write;
  assign ifIdWrite = ctl_out.if_id_write;
  assign ifIdFlush = ctl_out.if_id_flush;
  assign idExFlush = ctl_out.id_ex_flush;
  assign exStall   = ctl_out.ex_stall;
  assign stallErr  = stall_err_q;
  assign busyErr   = busy_err_q;

`ifdef HAZARD_STATS_EN
  logic stat_sat_load, stat_sat_flush, stat_sat_busy;
  logic unused_stat_sat;

  sat_counter #(.WIDTH(32)) u_stat_load (
    .clk(clk), .rst_n(rst_n), .clear_i(1'b0), .inc_i(stall_inc),
    .count_o(loadStallCount), .sat_o(stat_sat_load)
  );

  sat_counter #(.WIDTH(32)) u_stat_flush (
    .clk(clk), .rst_n(rst_n), .clear_i(1'b0), .inc_i(ctl.if_id_flush),
    .count_o(flushCount), .sat_o(stat_sat_flush)
  );

  sat_counter #(.WIDTH(32)) u_stat_busy (
    .clk(clk), .rst_n(rst_n), .clear_i(1'b0), .inc_i(busy_inc),
    .count_o(busyCycleCount), .sat_o(stat_sat_busy)
  );

  assign unused_stat_sat = stat_sat_load ^ stat_sat_flush ^ stat_sat_busy;
`else
  assign loadStallCount = '0;
  assign flushCount     = '0;
  assign busyCycleCount = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Randomized bench for pipeline_stall_controller against a counting reference model.
module tb_pipeline_stall_controller;

  localparam int FC  = 2;
  localparam int MLS = 1;
  localparam int BT  = 12;

  // Expected control vector: {pcWrite, ifIdWrite, ifIdFlush, idExFlush, exStall}
  localparam logic [4:0] V_RESET = 5'b00110;
  localparam logic [4:0] V_RUN   = 5'b11000;
  localparam logic [4:0] V_FREQ  = 5'b11110;
  localparam logic [4:0] V_FLUSH = 5'b11100;
  localparam logic [4:0] V_STALL = 5'b00010;
  localparam logic [4:0] V_BUSY  = 5'b00001;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stallReq = 1'b0, flushReq = 1'b0, longOpStart = 1'b0, longOpDone = 1'b0;
  logic        pcWrite, ifIdWrite, ifIdFlush, idExFlush, exStall, stallErr, busyErr;
  logic [31:0] loadStallCount, flushCount, busyCycleCount;

  int n_total = 0;
  int n_bad   = 0;
  logic [4:0] exp_q[$];

  // Reference model: remaining flush cycles, busy wait length, stall run length.
  int flush_left, waited, stall_run;
  bit busy, pending, m_stall_err, m_busy_err;
  int m_loads, m_flushes, m_busy_cycles;

  pipeline_stall_controller #(
    .FLUSH_CYCLES(FC), .MAX_LOAD_STALL(MLS), .BUSY_TIMEOUT(BT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stallReq(stallReq), .flushReq(flushReq),
    .longOpStart(longOpStart), .longOpDone(longOpDone),
    .pcWrite(pcWrite), .ifIdWrite(ifIdWrite), .ifIdFlush(ifIdFlush),
    .idExFlush(idExFlush), .exStall(exStall), .stallErr(stallErr), .busyErr(busyErr),
    .loadStallCount(loadStallCount), .flushCount(flushCount), .busyCycleCount(busyCycleCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    flush_left = 0; waited = 0; stall_run = 0;
    busy = 0; pending = 0; m_stall_err = 0; m_busy_err = 0;
    m_loads = 0; m_flushes = 0; m_busy_cycles = 0;
  endtask

  task automatic check_stats();
`ifdef HAZARD_STATS_EN
    check("loadStallCount", loadStallCount, m_loads);
    check("flushCount", flushCount, m_flushes);
    check("busyCycleCount", busyCycleCount, m_busy_cycles);
`else
    check("loadStallCount", loadStallCount, 0);
    check("flushCount", flushCount, 0);
    check("busyCycleCount", busyCycleCount, 0);
`endif
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    stallReq = 0; flushReq = 0; longOpStart = 0; longOpDone = 0;
    #2;
    check("reset_ctl", {pcWrite, ifIdWrite, ifIdFlush, idExFlush, exStall}, V_RESET);
    check("reset_stallErr", stallErr, 0);
    check("reset_busyErr", busyErr, 0);
    model_reset();
    check_stats();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic step(input bit fr, input bit st, input bit ls, input bit ld);
    logic [4:0] e;
    bit flush_now, set_serr, set_berr;
    @(posedge clk); #1;
    flushReq = fr; stallReq = st; longOpStart = ls; longOpDone = ld;
    #3;
    check("stallErr", stallErr, m_stall_err);
    check("busyErr", busyErr, m_busy_err);
    check_stats();

    e = V_RUN; flush_now = 0; set_serr = 0; set_berr = 0;
    if (busy) begin
      if (ld || waited == BT) begin
        if (!ld) set_berr = 1;
        flush_now = pending || fr;
        busy = 0; pending = 0;
      end else begin
        e = V_BUSY; waited++;
        if (fr) pending = 1;
      end
    end else if (flush_left > 0) begin
      e = V_FLUSH;
      flush_left = fr ? FC - 1 : flush_left - 1;
    end else if (fr) begin
      flush_now = 1;
    end else if (ls) begin
      if (!ld) begin busy = 1; waited = 0; end
    end else if (st) begin
      if (stall_run < MLS) begin e = V_STALL; stall_run++; m_loads++; end
      else set_serr = 1;
    end
    if (flush_now) begin e = V_FREQ; flush_left = FC - 1; end
    if (!st) stall_run = 0;
    if (e[2]) m_flushes++;
    if (e[0]) m_busy_cycles++;

    exp_q.push_back(e);
    check("ctl", {pcWrite, ifIdWrite, ifIdFlush, idExFlush, exStall}, exp_q.pop_front());
    if (set_serr) m_stall_err = 1;
    if (set_berr) m_busy_err = 1;
  endtask

  initial begin
    model_reset();
    do_reset();
    repeat (2) step(0, 0, 0, 0);

    // single load-use stall, then runaway stall held three cycles
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    repeat (3) step(0, 1, 0, 0);
    step(0, 0, 0, 0);
    check("stallErr_sticky", stallErr, 1);

    // branch with simultaneous stall requests
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    step(0, 0, 0, 0);

    // long op of ten stalled cycles with a deferred flush
    step(0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0);
    step(1, 1, 0, 0);
    repeat (6) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    repeat (3) step(0, 0, 0, 0);

    // timeout with no done
    step(0, 0, 1, 0);
    repeat (BT + 2) step(0, 0, 0, 0);
    check("busyErr_after_timeout", busyErr, 1);

    // zero-wait op and stray done
    step(0, 0, 1, 1);
    step(0, 0, 0, 1);

    // reset in the middle of a long op
    do_reset();
    step(0, 0, 1, 0);
    repeat (4) step(0, 0, 0, 0);
    do_reset();
    repeat (2) step(0, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 399) do_reset();
      step($urandom_range(0, 99) < 10, $urandom_range(0, 99) < 30,
           $urandom_range(0, 99) < 8, $urandom_range(0, 99) < 12);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/pipeline_stall_controller.md
Name: pipeline_stall_controller

Overview:
- Consumes the hazard-detection stall/flush requests and the EX-stage multi-cycle-op handshake.
- Drives the pipeline-register and PC enables of the 5-stage MIPS core: PC, IF/ID, ID/EX bubble, EX hold.
- Owns the sequencing the detector lacks: bounded stall length, multi-cycle flush, long-op wait with timeout, and a deferred flush.

Parameters:
- FLUSH_CYCLES, 1, consecutive cycles IF/ID is flushed per taken branch/jump (1..4).
- MAX_LOAD_STALL, 1, maximum consecutive load-use stall cycles honoured (1..7).
- BUSY_TIMEOUT, 64, maximum cycles spent waiting for longOpDone (2..255).

Ports:
- clk  in  1  core clock.
- rst_n  in  1  asynchronous active-low reset.
- stallReq  in  1  load-use stall request from hazard detection.
- flushReq  in  1  taken branch/jump resolved; discard younger instructions.
- longOpStart  in  1  multi-cycle EX op (mult/div) begins this cycle.
- longOpDone  in  1  multi-cycle op result valid this cycle.
- pcWrite  out  1  PC update enable.
- ifIdWrite  out  1  IF/ID register write enable.
- ifIdFlush  out  1  IF/ID register clear to NOP.
- idExFlush  out  1  insert bubble into ID/EX.
- exStall  out  1  hold ID/EX and EX/MEM contents.
- stallErr  out  1  sticky: stallReq exceeded MAX_LOAD_STALL.
- busyErr  out  1  sticky: BUSY_TIMEOUT expired.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- While rst_n is low:
  - State goes to RUN; all counters and pendingFlush clear; stallErr and busyErr clear.
  - Outputs are gated: pcWrite=0, ifIdWrite=0, ifIdFlush=1, idExFlush=1, exStall=0.
- Outputs are combinational from registered state plus current inputs (zero latency, as required for load-use). State and counters update on posedge clk.
- States: RUN, FLUSH, BUSY.
- RUN, default outputs: pcWrite=1, ifIdWrite=1, all flushes 0, exStall=0.
- RUN input priority: flushReq > longOpStart > stallReq.
  - flushReq: ifIdFlush=1, idExFlush=1, pcWrite=1. Next state is FLUSH if FLUSH_CYCLES>1, else RUN. Flush counter loads FLUSH_CYCLES-1.
  - longOpStart: outputs stay default this cycle. Next state BUSY; busy counter clears.
  - stallReq: pcWrite=0, ifIdWrite=0, idExFlush=1. Consecutive-stall counter increments.
    - When the counter equals MAX_LOAD_STALL and stallReq is still high: request ignored (default outputs), stallErr set.
    - Counter clears on any cycle stallReq is low.
- FLUSH:
  - Outputs: ifIdFlush=1, pcWrite=1, ifIdWrite=1.
  - Counter decrements; exit to RUN when it reaches 0.
  - stallReq and longOpStart are ignored (wrong-path instructions).
  - A new flushReq reloads the counter.
- BUSY:
  - Outputs: pcWrite=0, ifIdWrite=0, exStall=1, idExFlush=0.
  - stallReq ignored.
  - flushReq sets pendingFlush.
  - longOpDone: outputs revert to RUN defaults in the same cycle; next state RUN.
  - If pendingFlush was set, the exit cycle instead behaves as a RUN flushReq cycle, and pendingFlush clears.
  - Busy counter saturates at BUSY_TIMEOUT: forced exit to RUN, busyErr set, pendingFlush honoured.
- longOpDone while not in BUSY: ignored.
- longOpStart and longOpDone in the same cycle while in RUN: treated as a zero-wait op; stay in RUN.
- Counter widths: clog2 of the respective parameter plus 1; no wrap.

Optional Feature:
- Macro: HAZARD_STATS_EN.
- Defined: adds 32-bit outputs loadStallCount, flushCount, busyCycleCount.
  - Each counter increments once per cycle in which its condition drives the pipeline.
  - Each saturates at 0xFFFFFFFF and clears on reset.
- Undefined: the same ports exist, tied to 0; no counter flops are synthesized.

Decomposition:
- Shared header/package hazard_pkg holds:
  - state encodings: RUN=2'd0, FLUSH=2'd1, BUSY=2'd2;
  - the reset output vector;
  - the parameter legal ranges.
- One sub-module, sat_counter (parameter WIDTH; clear, inc, saturated flag). Instantiated for:
  - the stall, flush and busy counters;
  - the three stats counters.

Test Plan:
- Reset mid-BUSY: rst_n low at cycle 5 of a long op -> outputs take the reset values immediately; after release: RUN, pcWrite=1, busyErr=0.
- Single load-use: stallReq high 1 cycle -> pcWrite=0, ifIdWrite=0, idExFlush=1 that cycle only; stallErr=0.
- Runaway stall, MAX_LOAD_STALL=1: stallReq held 3 cycles -> cycle 1 stalls; cycles 2-3 default outputs; stallErr=1 and stays sticky.
- Branch with FLUSH_CYCLES=2: flushReq 1 cycle -> ifIdFlush=1 for 2 cycles; idExFlush=1 in the first only; simultaneous stallReq ignored.
- Long op: longOpStart, then longOpDone 10 cycles later, with flushReq during BUSY -> exStall=1 for 10 cycles; the exit cycle has ifIdFlush=1, idExFlush=1.
- Timeout, BUSY_TIMEOUT=4, no longOpDone -> forced RUN after 4 BUSY cycles; busyErr=1. With HAZARD_STATS_EN: busyCycleCount=4.
